// File: rtl/alu_pkg.sv
// Shared constants for the sequential Forth ALU: opcode map, error codes, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package alu_pkg;

    // Opcode map, shared with the old combinational ALU
    localparam logic [3:0] ALU_NOP = 4'd0;   // illegal: res=0, err=ERR_ILL
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_MUL = 4'd3;
    localparam logic [3:0] ALU_DIV = 4'd4;
    localparam logic [3:0] ALU_MOD = 4'd5;
    localparam logic [3:0] ALU_AND = 4'd6;
    localparam logic [3:0] ALU_OR  = 4'd7;
    localparam logic [3:0] ALU_XOR = 4'd8;
    localparam logic [3:0] ALU_NOT = 4'd9;   // ~B
    localparam logic [3:0] ALU_PSB = 4'd10;  // pass B
    localparam logic [3:0] ALU_SHL = 4'd11;
    localparam logic [3:0] ALU_SHR = 4'd12;  // logical
    localparam logic [3:0] ALU_LT  = 4'd13;  // signed
    localparam logic [3:0] ALU_GE  = 4'd14;  // signed
    localparam logic [3:0] ALU_EQ  = 4'd15;

    // Error codes reported alongside the result
    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_DIV0 = 2'd1;
    localparam logic [1:0] ERR_ILL  = 2'd2;

    // Control FSM. Single-cycle ops are evaluated on the accept edge, so
    // they go straight from IDLE to DONE without a separate execute state.
    typedef logic [1:0] alu_state_t;
    localparam alu_state_t S_IDLE = 2'd0;
    localparam alu_state_t S_MUL  = 2'd1;
    localparam alu_state_t S_DIV  = 2'd2;
    localparam alu_state_t S_DONE = 2'd3;

endpackage

// File: rtl/alu_divider.sv
// Iterative signed restoring divider: truncating quotient, remainder takes the dividend's sign.
// Latency: start accepted on a clock edge, WIDTH magnitude iterations, then one sign-fix cycle with o_done=1.
// Backpressure: none; i_start is ignored while o_busy, and o_q/o_r are only valid while o_done.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   i_start         load i_a/i_b and begin (divisor must be non-zero)
//   i_a, i_b        signed dividend / divisor
//   o_busy          iteration or sign-fix in progress
//   o_done          one-cycle pulse, o_q/o_r valid this cycle
//   o_q, o_r        signed quotient / remainder
module alu_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_r
);

    localparam int CW = $clog2(WIDTH);

    logic             r_run;
    logic             r_fix;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quo;    // dividend shifts out the top, quotient bits shift in
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;    // divisor magnitude
    logic             r_neg_q;
    logic             r_neg_r;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;

    // |MIN| wraps to MIN, which as an unsigned magnitude is exactly right.
    assign w_abs_a = i_a[WIDTH-1] ? -i_a : i_a;
    assign w_abs_b = i_b[WIDTH-1] ? -i_b : i_b;

    // One extra bit: the shifted partial remainder can reach 2*divisor-1.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_fits  = ~w_diff[WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run   <= 1'b0;
            r_fix   <= 1'b0;
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (i_start && !o_busy) begin
            r_quo   <= w_abs_a;
            r_dvs   <= w_abs_b;
            r_rem   <= '0;
            r_neg_q <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
            r_neg_r <= i_a[WIDTH-1];
            r_cnt   <= '0;
            r_run   <= 1'b1;
            r_fix   <= 1'b0;
        end else if (r_run) begin
            r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_fits};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH - 1)) begin
                r_run <= 1'b0;
                r_fix <= 1'b1;
            end
        end else if (r_fix) begin
            r_fix <= 1'b0;
        end
    end

    assign o_busy = r_run | r_fix;
    assign o_done = r_fix;
    // Sign fix happens combinationally during the done cycle.
    assign o_q    = r_neg_q ? -r_quo : r_quo;
    assign o_r    = r_neg_r ? -r_rem : r_rem;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle Forth ALU (A=NOS, B=TOS) with valid/ready handshake, iterative divider and optional sequential multiplier.
// Latency: single-cycle ops and divide-by-zero 1 cycle after accept; seq mul WIDTH+1; div/mod WIDTH+2.
// Backpressure: one op outstanding; in_ready only in IDLE; result held stable until out_valid&&out_ready.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid/in_ready      request handshake; op/a/b captured on accept
//   op                     4-bit opcode (see alu_pkg)
//   a, b                   signed operands
//   out_valid/out_ready    result handshake
//   res, err               result and error code (ERR_OK/ERR_DIV0/ERR_ILL)
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MUL_SEQ = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [1:0]       err
);

    localparam int CW = $clog2(WIDTH);

    alu_state_t       r_state;
    logic [WIDTH-1:0] r_res;
    logic [1:0]       r_err;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic             r_is_mod;

    logic             w_accept;
    logic             w_is_seq_mul;
    logic             w_is_divmod;
    logic             w_div_start;
    logic             w_div_busy;
    logic             w_div_done;
    logic [WIDTH-1:0] w_div_q;
    logic [WIDTH-1:0] w_div_r;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_shamt_big;
    logic [WIDTH-1:0] w_res_1c;
    logic [1:0]       w_err_1c;

    assign in_ready  = (r_state == S_IDLE) && !w_div_busy;
    assign out_valid = (r_state == S_DONE);
    assign res       = r_res;
    assign err       = r_err;

    assign w_accept     = in_valid && in_ready;
    assign w_is_seq_mul = (MUL_SEQ != 0) && (op == ALU_MUL);
    assign w_is_divmod  = (op == ALU_DIV) || (op == ALU_MOD);
    // Divide by zero never starts the divider; it is answered on the accept edge.
    assign w_div_start  = w_accept && w_is_divmod && (b != '0);

    // Any bit at or above log2(WIDTH) set means the shift clears everything.
    assign w_shamt_big  = |b[WIDTH-1:CW];

    // Shift-add step: add the (pre-shifted) multiplicand when the current multiplier LSB is set.
    assign w_acc_next   = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Results that are complete on the accept edge, taken straight from the ports.
    always_comb begin
        w_res_1c = '0;
        w_err_1c = ERR_OK;
        case (op)
            ALU_NOP: w_err_1c = ERR_ILL;
            ALU_ADD: w_res_1c = a + b;
            ALU_SUB: w_res_1c = a - b;
            ALU_MUL: w_res_1c = a * b;
            ALU_DIV: begin
                w_res_1c = '1;
                w_err_1c = ERR_DIV0;
            end
            ALU_MOD: begin
                w_res_1c = a;
                w_err_1c = ERR_DIV0;
            end
            ALU_AND: w_res_1c = a & b;
            ALU_OR:  w_res_1c = a | b;
            ALU_XOR: w_res_1c = a ^ b;
            ALU_NOT: w_res_1c = ~b;
            ALU_PSB: w_res_1c = b;
            ALU_SHL: w_res_1c = w_shamt_big ? '0 : (a << b[CW-1:0]);
            ALU_SHR: w_res_1c = w_shamt_big ? '0 : (a >> b[CW-1:0]);
            ALU_LT:  w_res_1c[0] = ($signed(a) <  $signed(b));
            ALU_GE:  w_res_1c[0] = ($signed(a) >= $signed(b));
            ALU_EQ:  w_res_1c[0] = (a == b);
            default: w_res_1c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_res    <= '0;
            r_err    <= ERR_OK;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_is_mod <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_seq_mul) begin
                            r_mcand  <= a;
                            r_mplier <= b;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_state  <= S_MUL;
                        end else if (w_div_start) begin
                            r_is_mod <= (op == ALU_MOD);
                            r_state  <= S_DIV;
                        end else begin
                            r_res    <= w_res_1c;
                            r_err    <= w_err_1c;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_res   <= w_acc_next;
                        r_err   <= ERR_OK;
                        r_state <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (w_div_done) begin
                        r_res   <= r_is_mod ? w_div_r : w_div_q;
                        r_err   <= ERR_OK;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // No accept in the retire cycle: in_ready rises one cycle later.
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    alu_divider #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_div_start),
        .i_a     (a),
        .i_b     (b),
        .o_busy  (w_div_busy),
        .o_done  (w_div_done),
        .o_q     (w_div_q),
        .o_r     (w_div_r)
    );

endmodule
